// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_pkg
//  Description : Shared types and default widths for the two-client ALU
//                sharing controller (FSM states, owner encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ALUC_W_DEF = 2;
    localparam int CNT_W_DEF  = 16;

    // Controller states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Client identity, used for the owner register and the round-robin pointer
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin picker. When both clients
//                request, the one not granted last wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic   valid_a,
    input  logic   valid_b,
    input  owner_t last,
    output logic   grant_a,
    output logic   grant_b,
    output owner_t winner
);

    // A wins when alone or when B was served last; B symmetrically
    always_comb begin
        grant_a = valid_a & (~valid_b | (last == OWN_B));
        grant_b = valid_b & (~valid_a | (last == OWN_A));
        winner  = grant_b ? OWN_B : OWN_A;
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arb
//  Description : Shares one ALU between two clients. Round-robin arbitration
//                in IDLE, one EXEC cycle to capture the ALU result, then a
//                valid/ready response to the owning client.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ALUC_W = ALUC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
)(
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              req_valid_a,
    input  logic              req_valid_b,
    output logic              req_ready_a,
    output logic              req_ready_b,
    input  logic [WIDTH-1:0]  req_x_a,
    input  logic [WIDTH-1:0]  req_y_a,
    input  logic [WIDTH-1:0]  req_x_b,
    input  logic [WIDTH-1:0]  req_y_b,
    input  logic [ALUC_W-1:0] req_aluc_a,
    input  logic [ALUC_W-1:0] req_aluc_b,
    output logic              rsp_valid_a,
    output logic              rsp_valid_b,
    input  logic              rsp_ready_a,
    input  logic              rsp_ready_b,
    output logic [WIDTH-1:0]  rsp_r,
    output logic              rsp_z,
    output logic [WIDTH-1:0]  alu_x,
    output logic [WIDTH-1:0]  alu_y,
    output logic [ALUC_W-1:0] alu_aluc,
    input  logic [WIDTH-1:0]  alu_r,
    input  logic              alu_z,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    state_t              r_state;
    state_t              w_state_nxt;
    owner_t              r_last;
    owner_t              r_owner;
    logic [WIDTH-1:0]    r_x;
    logic [WIDTH-1:0]    r_y;
    logic [ALUC_W-1:0]   r_aluc;
    logic [WIDTH-1:0]    r_res;
    logic                r_zero;
    logic [CNT_W-1:0]    r_ops;

    logic                w_grant_a;
    logic                w_grant_b;
    owner_t              w_winner;
    logic                w_req_take;
    logic                w_rsp_take;

    rr_arb2 u_rr_arb2 (
        .valid_a (req_valid_a),
        .valid_b (req_valid_b),
        .last    (r_last),
        .grant_a (w_grant_a),
        .grant_b (w_grant_b),
        .winner  (w_winner)
    );

    // Next-state and handshake outputs; ready/valid are forced low in reset
    always_comb begin
        w_state_nxt = r_state;
        w_req_take  = 1'b0;
        w_rsp_take  = 1'b0;
        req_ready_a = 1'b0;
        req_ready_b = 1'b0;
        rsp_valid_a = 1'b0;
        rsp_valid_b = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_a = Clrn & w_grant_a;
                req_ready_b = Clrn & w_grant_b;
                if (w_grant_a | w_grant_b) begin
                    w_req_take  = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_a = Clrn & (r_owner == OWN_A);
                rsp_valid_b = Clrn & (r_owner == OWN_B);
                // Only the owner's ready counts; the other client is ignored
                w_rsp_take  = (r_owner == OWN_A) ? rsp_ready_a : rsp_ready_b;
                if (w_rsp_take) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand/result capture, round-robin pointer and completion counter
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            r_last  <= OWN_B;
            r_owner <= OWN_A;
            r_x     <= '0;
            r_y     <= '0;
            r_aluc  <= '0;
            r_res   <= '0;
            r_zero  <= 1'b0;
            r_ops   <= '0;
        end else begin
            if (w_req_take) begin
                r_owner <= w_winner;
                r_x     <= (w_winner == OWN_B) ? req_x_b    : req_x_a;
                r_y     <= (w_winner == OWN_B) ? req_y_b    : req_y_a;
                r_aluc  <= (w_winner == OWN_B) ? req_aluc_b : req_aluc_a;
            end
            if (r_state == ST_EXEC) begin
                r_res  <= alu_r;
                r_zero <= alu_z;
            end
            if (w_rsp_take) begin
                r_last <= r_owner;
                r_ops  <= r_ops + CNT_W'(1);
            end
        end
    end

    assign alu_x    = r_x;
    assign alu_y    = r_y;
    assign alu_aluc = r_aluc;
    assign rsp_r    = r_res;
    assign rsp_z    = r_zero;
    assign busy     = (r_state != ST_IDLE);
    assign ops_done = r_ops;

endmodule : alu_share_arb
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arb
//  Description : Directed self-checking bench for alu_share_arb with an
//                adder stub ALU (R = X+Y, Z = R==0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;

    localparam int WIDTH  = 32;
    localparam int ALUC_W = 2;
    localparam int CNT_W  = 8;   // narrow counter so the wrap is reached quickly

    logic              Clk = 1'b0;
    logic              Clrn;
    logic              req_valid_a, req_valid_b;
    logic              req_ready_a, req_ready_b;
    logic [WIDTH-1:0]  req_x_a, req_y_a, req_x_b, req_y_b;
    logic [ALUC_W-1:0] req_aluc_a, req_aluc_b;
    logic              rsp_valid_a, rsp_valid_b;
    logic              rsp_ready_a, rsp_ready_b;
    logic [WIDTH-1:0]  rsp_r;
    logic              rsp_z;
    logic [WIDTH-1:0]  alu_x, alu_y, alu_r;
    logic [ALUC_W-1:0] alu_aluc;
    logic              alu_z;
    logic              busy;
    logic [CNT_W-1:0]  ops_done;

    int n_chk = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_ops;

    always #5 Clk = ~Clk;

    // Stub ALU
    assign alu_r = alu_x + alu_y;
    assign alu_z = (alu_r == '0);

    alu_share_arb #(.WIDTH(WIDTH), .ALUC_W(ALUC_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Clrn(Clrn),
        .req_valid_a(req_valid_a), .req_valid_b(req_valid_b),
        .req_ready_a(req_ready_a), .req_ready_b(req_ready_b),
        .req_x_a(req_x_a), .req_y_a(req_y_a), .req_x_b(req_x_b), .req_y_b(req_y_b),
        .req_aluc_a(req_aluc_a), .req_aluc_b(req_aluc_b),
        .rsp_valid_a(rsp_valid_a), .rsp_valid_b(rsp_valid_b),
        .rsp_ready_a(rsp_ready_a), .rsp_ready_b(rsp_ready_b),
        .rsp_r(rsp_r), .rsp_z(rsp_z),
        .alu_x(alu_x), .alu_y(alu_y), .alu_aluc(alu_aluc),
        .alu_r(alu_r), .alu_z(alu_z),
        .busy(busy), .ops_done(ops_done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Two cycles of reset, ending at a falling edge with Clrn released
    task automatic do_reset();
        @(negedge Clk);
        Clrn = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Clrn = 1'b1;
        exp_ops = '0;
    endtask

    // One single-client op, starting and ending at a falling edge in IDLE
    task automatic run_op(input bit cl, input logic [31:0] x, input logic [31:0] y,
                          input bit do_chk);
        logic [31:0] er;
        er = x + y;
        if (cl) begin req_valid_b = 1'b1; req_x_b = x; req_y_b = y; req_aluc_b = 2'b10; end
        else    begin req_valid_a = 1'b1; req_x_a = x; req_y_a = y; req_aluc_a = 2'b10; end
        #1;
        if (do_chk) chk("req_ready", cl ? req_ready_b : req_ready_a, 1);
        @(posedge Clk); @(negedge Clk);
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_x_a = 32'hDEAD_BEEF; req_x_b = 32'hDEAD_BEEF;  // late change must not matter
        #1;
        if (do_chk) chk("exec_no_rsp", {rsp_valid_a, rsp_valid_b}, 0);
        @(posedge Clk); @(negedge Clk);
        #1;
        if (do_chk) begin
            chk("rsp_valid_own", cl ? rsp_valid_b : rsp_valid_a, 1);
            chk("rsp_valid_other", cl ? rsp_valid_a : rsp_valid_b, 0);
            chk("rsp_r", rsp_r, er);
            chk("rsp_z", rsp_z, (er == 0) ? 1 : 0);
        end
        if (cl) rsp_ready_b = 1'b1; else rsp_ready_a = 1'b1;
        @(posedge Clk); @(negedge Clk);
        rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
        exp_ops = exp_ops + 1'b1;
    endtask

    initial begin
        logic [31:0] hold_r;
        Clrn = 1'b0;
        req_valid_a = 0; req_valid_b = 0;
        req_x_a = 0; req_y_a = 0; req_x_b = 0; req_y_b = 0;
        req_aluc_a = 0; req_aluc_b = 0;
        rsp_ready_a = 0; rsp_ready_b = 0;
        exp_ops = '0;

        // Ready forced low during reset even with a request pending
        @(negedge Clk);
        req_valid_a = 1'b1;
        #1 chk("ready_in_reset", req_ready_a, 0);
        req_valid_a = 1'b0;
        do_reset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ops", ops_done, 0);
        chk("rst_alu_x", alu_x, 0);
        chk("rst_rsp_r", rsp_r, 0);

        // A alone: 0xC + 0xA = 0x16
        run_op(1'b0, 32'hC, 32'hA, 1'b1);
        #1 chk("ops_after_first", ops_done, 1);

        // Both valid from reset: strict alternation A, B, A, B
        do_reset();
        req_valid_a = 1; req_x_a = 1; req_y_a = 2; req_aluc_a = 2'b01;
        req_valid_b = 1; req_x_b = 5; req_y_b = 6; req_aluc_b = 2'b11;
        rsp_ready_a = 1; rsp_ready_b = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready_a", req_ready_a, (i % 2 == 0) ? 1 : 0);
            chk("rr_ready_b", req_ready_b, (i % 2 == 1) ? 1 : 0);
            @(posedge Clk); @(negedge Clk);
            #1 chk("rr_exec_no_ready", {req_ready_a, req_ready_b}, 0);
            @(posedge Clk); @(negedge Clk);
            #1;
            chk("rr_rsp_a", rsp_valid_a, (i % 2 == 0) ? 1 : 0);
            chk("rr_rsp_b", rsp_valid_b, (i % 2 == 1) ? 1 : 0);
            chk("rr_rsp_r", rsp_r, (i % 2 == 0) ? 3 : 11);
            @(posedge Clk); @(negedge Clk);
        end
        req_valid_a = 0; req_valid_b = 0; rsp_ready_a = 0; rsp_ready_b = 0;
        #1 chk("rr_ops", ops_done, 4);

        // Held response for A while B waits; B's ready must be ignored
        do_reset();
        req_valid_a = 1; req_x_a = 32'h100; req_y_a = 32'h23;
        @(posedge Clk); @(negedge Clk);
        req_valid_a = 0;
        req_valid_b = 1; req_x_b = 32'hFFFF_FFFF; req_y_b = 1; rsp_ready_b = 1;
        @(posedge Clk); @(negedge Clk);
        #1 hold_r = rsp_r;
        chk("hold_r_value", hold_r, 32'h123);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_valid", rsp_valid_a, 1);
            chk("hold_r", rsp_r, hold_r);
            chk("hold_ready_b", req_ready_b, 0);
            chk("hold_busy", busy, 1);
            @(posedge Clk); @(negedge Clk);
        end
        rsp_ready_b = 0;
        rsp_ready_a = 1;
        @(posedge Clk); @(negedge Clk);
        rsp_ready_a = 0;
        #1 chk("b_ready_after_take", req_ready_b, 1);
        @(posedge Clk); @(negedge Clk);
        req_valid_b = 0;
        @(posedge Clk); @(negedge Clk);
        #1;
        chk("b_rsp_valid", rsp_valid_b, 1);
        chk("b_rsp_r_zero", rsp_r, 0);
        chk("b_rsp_z", rsp_z, 1);
        rsp_ready_b = 1;
        @(posedge Clk); @(negedge Clk);
        rsp_ready_b = 0;
        #1 chk("hold_ops", ops_done, 2);

        // Reset during EXEC drops the op
        req_valid_a = 1; req_x_a = 7; req_y_a = 8;
        @(posedge Clk); @(negedge Clk);
        #1 chk("mid_busy", busy, 1);
        Clrn = 0; req_valid_a = 1; rsp_ready_a = 1;
        @(posedge Clk); @(negedge Clk);
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp", {rsp_valid_a, rsp_valid_b}, 0);
        chk("mid_rst_ready", req_ready_a, 0);
        chk("mid_rst_ops", ops_done, 0);
        req_valid_a = 0; rsp_ready_a = 0;
        Clrn = 1;
        exp_ops = '0;
        run_op(1'b1, 32'h20, 32'h22, 1'b1);
        #1 chk("post_rst_ops", ops_done, exp_ops);

        // Counter wrap
        while (exp_ops != '1) run_op(exp_ops[0], exp_ops, 32'h1, 1'b0);
        #1 chk("ops_max", ops_done, {CNT_W{1'b1}});
        run_op(1'b0, 32'h3, 32'h4, 1'b0);
        #1 chk("ops_wrap", ops_done, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_alu_share_arb
`default_nettype wire
